// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Ties alternate between requesters; the result is held in a one-entry output register.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [1:0]       req0_mode,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [1:0]       req1_mode,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [1:0]       alu_mode,
  input  logic [WIDTH-1:0] alu_result,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  input  logic             res_ready
);

  logic last_grant;
  logic grant_valid;
  logic grant_idx;
  logic can_accept;
  logic accept;

  // Ties go to whichever requester was not served last.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = req1_valid;
    end
  end

  // rst_n gates acceptance so both readies stay low for the whole reset pulse.
  always_comb begin
    can_accept = ~res_valid | res_ready;
    accept     = grant_valid & can_accept & rst_n;
    req0_ready = accept & ~grant_idx;
    req1_ready = accept & grant_idx;
  end

  always_comb begin
    alu_op1  = '0;
    alu_op2  = '0;
    alu_mode = 2'b11;
    if (grant_valid) begin
      if (grant_idx) begin
        alu_op1  = req1_op1;
        alu_op2  = req1_op2;
        alu_mode = req1_mode;
      end else begin
        alu_op1  = req0_op1;
        alu_op2  = req0_op2;
        alu_mode = req0_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      res_valid  <= 1'b1;
      res_data   <= alu_result;
      res_id     <= grant_idx;
      last_grant <= grant_idx;
    end else if (res_valid && res_ready) begin
      res_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [1:0]       req0_mode, req1_mode;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] alu_op1, alu_op2, alu_result;
  logic [1:0]       alu_mode;
  logic             res_valid, res_id, res_ready;
  logic [WIDTH-1:0] res_data;

  int tests;
  int fails;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req0_mode(req0_mode), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req1_mode(req1_mode), .req1_ready(req1_ready),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_mode(alu_mode),
    .alu_result(alu_result),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU that sits outside the arbiter.
  always_comb begin
    case (alu_mode)
      2'b00:   alu_result = alu_op1 + alu_op2;
      2'b01:   alu_result = ~alu_op1;
      2'b10:   alu_result = alu_op2;
      default: alu_result = '0;
    endcase
  end

  // Reference ALU expressed as plain integer arithmetic.
  function automatic int unsigned ref_alu(int unsigned a, int unsigned b, int unsigned m);
    case (m)
      0:       return (a + b) % 65536;
      1:       return 65535 - a;
      2:       return b;
      default: return 0;
    endcase
  endfunction

  task automatic set_req0(logic v, logic [15:0] a, logic [15:0] b, logic [1:0] m);
    req0_valid = v; req0_op1 = a; req0_op2 = b; req0_mode = m;
  endtask

  task automatic set_req1(logic v, logic [15:0] a, logic [15:0] b, logic [1:0] m);
    req1_valid = v; req1_op1 = a; req1_op2 = b; req1_mode = m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_req0(1'b0, '0, '0, 2'b00);
    set_req1(1'b0, '0, '0, 2'b00);
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_drain();
    @(negedge clk);
    set_req0(1'b0, '0, '0, 2'b00);
    set_req1(1'b0, '0, '0, 2'b00);
    res_ready = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_req0(1'b1, 16'h0001, 16'h0002, 2'b00);
    set_req1(1'b1, 16'h0003, 16'h0004, 2'b00);
    res_ready = 1'b1;
    #1;
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", res_valid); end
    tests++; if (res_data !== 16'h0000) begin fails++; $display("FAIL reset_data got %h want 0000", res_data); end
    tests++; if (res_id !== 1'b0) begin fails++; $display("FAIL reset_id got %b want 0", res_id); end
    tests++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_hold_valid got %b want 0", res_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    set_req0(1'b0, '0, '0, 2'b00);
    set_req1(1'b0, '0, '0, 2'b00);
    @(posedge clk);
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req0(1'b1, 16'h0003, 16'h0004, 2'b00);
    res_ready = 1'b1;
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready}); end
    tests++; if ({alu_op1, alu_op2, alu_mode} !== {16'h0003, 16'h0004, 2'b00}) begin
      fails++; $display("FAIL single_mux got %h/%h/%b want 0003/0004/00", alu_op1, alu_op2, alu_mode);
    end
    @(posedge clk); #1;
    set_req0(1'b0, '0, '0, 2'b00);
    tests++; if ({res_valid, res_data, res_id} !== {1'b1, 16'h0007, 1'b0}) begin
      fails++; $display("FAIL single_result got v=%b d=%h id=%b want v=1 d=0007 id=0", res_valid, res_data, res_id);
    end
  endtask

  task automatic test_tie();
    do_reset();
    set_req0(1'b1, 16'h0010, 16'h0001, 2'b00);
    set_req1(1'b1, 16'h0020, 16'h0002, 2'b00);
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_id;
      exp_id = k[0];
      #1;
      tests++; if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin
        fails++; $display("FAIL tie_ready[%0d] got %b want %b", k, {req0_ready, req1_ready}, {~exp_id, exp_id});
      end
      @(posedge clk); #1;
      tests++; if ({res_valid, res_id} !== {1'b1, exp_id}) begin
        fails++; $display("FAIL tie_id[%0d] got v=%b id=%b want v=1 id=%b", k, res_valid, res_id, exp_id);
      end
      @(negedge clk);
    end
    idle_drain();
  endtask

  task automatic test_backpressure();
    idle_drain();
    @(negedge clk);
    set_req0(1'b1, 16'h0000, 16'h00FF, 2'b10);
    res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    set_req0(1'b0, '0, '0, 2'b00);
    set_req1(1'b1, 16'h0001, 16'h0002, 2'b00);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if ({req0_ready, req1_ready} !== 2'b00) begin
        fails++; $display("FAIL bp_ready[%0d] got %b want 00", k, {req0_ready, req1_ready});
      end
      @(posedge clk); #1;
      tests++; if ({res_valid, res_data, res_id} !== {1'b1, 16'h00FF, 1'b0}) begin
        fails++; $display("FAIL bp_hold[%0d] got v=%b d=%h id=%b want v=1 d=00ff id=0", k, res_valid, res_data, res_id);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    tests++; if (req1_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", req1_ready); end
    @(posedge clk); #1;
    tests++; if ({res_valid, res_data, res_id} !== {1'b1, 16'h0003, 1'b1}) begin
      fails++; $display("FAIL bp_release_result got v=%b d=%h id=%b want v=1 d=0003 id=1", res_valid, res_data, res_id);
    end
    idle_drain();
  endtask

  task automatic test_modes();
    logic [15:0] a[4]   = '{16'hFFFF, 16'h00F0, 16'h5555, 16'hABCD};
    logic [15:0] b[4]   = '{16'h0001, 16'h0000, 16'h1234, 16'h1111};
    logic [15:0] exp[4] = '{16'h0000, 16'hFF0F, 16'h1234, 16'h0000};
    for (int k = 0; k < 4; k++) begin
      logic [1:0] m;
      m = 2'(k);
      @(negedge clk);
      set_req0(1'b1, a[k], b[k], m);
      res_ready = 1'b1;
      @(posedge clk); #1;
      tests++; if ({res_valid, res_data} !== {1'b1, exp[k]}) begin
        fails++; $display("FAIL mode%0d_result got v=%b d=%h want v=1 d=%h", k, res_valid, res_data, exp[k]);
      end
    end
    idle_drain();
  endtask

  task automatic test_idle();
    logic [15:0] last;
    @(negedge clk);
    set_req0(1'b1, 16'h0102, 16'h0304, 2'b00);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_req0(1'b0, 16'h7777, 16'h8888, 2'b01);
    last = 16'h0406;
    #1;
    tests++; if ({alu_op1, alu_op2, alu_mode, req0_ready, req1_ready} !== {16'h0000, 16'h0000, 2'b11, 2'b00}) begin
      fails++; $display("FAIL idle_outputs got %h/%h/%b rdy=%b%b want 0000/0000/11 rdy=00",
                        alu_op1, alu_op2, alu_mode, req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    tests++; if ({res_valid, res_data, res_id} !== {1'b0, last, 1'b0}) begin
      fails++; $display("FAIL idle_drain got v=%b d=%h id=%b want v=0 d=%h id=0", res_valid, res_data, res_id, last);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_req0(1'b1, 16'h0001, 16'h0001, 2'b00);
    res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    set_req0(1'b0, '0, '0, 2'b00);
    set_req1(1'b1, 16'h0005, 16'h0006, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if ({res_valid, res_data, req0_ready, req1_ready} !== {1'b0, 16'h0000, 2'b00}) begin
      fails++; $display("FAIL midreset got v=%b d=%h rdy=%b%b want v=0 d=0000 rdy=00", res_valid, res_data, req0_ready, req1_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    #1;
    tests++; if (req1_ready !== 1'b1) begin fails++; $display("FAIL midreset_req1_ready got %b want 1", req1_ready); end
    @(posedge clk); #1;
    tests++; if ({res_valid, res_data, res_id} !== {1'b1, 16'h000B, 1'b1}) begin
      fails++; $display("FAIL midreset_result got v=%b d=%h id=%b want v=1 d=000b id=1", res_valid, res_data, res_id);
    end
    idle_drain();
  endtask

  // Reference model holds the pending transaction and the last served requester.
  task automatic test_random();
    bit          m_valid = 1'b0;
    int unsigned m_data  = 0;
    int          m_id    = 0;
    int          m_last  = 1;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      int          winner;
      bit          can;
      int unsigned e_op1, e_op2, e_mode;
      @(negedge clk);
      set_req0(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 2'($urandom));
      set_req1(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 2'($urandom));
      res_ready = ($urandom_range(0, 3) != 0);
      can = !m_valid || res_ready;
      if (req0_valid && req1_valid) winner = (m_last == 0) ? 1 : 0;
      else if (req0_valid)          winner = 0;
      else if (req1_valid)          winner = 1;
      else                          winner = -1;
      if (winner == 0)      begin e_op1 = req0_op1; e_op2 = req0_op2; e_mode = req0_mode; end
      else if (winner == 1) begin e_op1 = req1_op1; e_op2 = req1_op2; e_mode = req1_mode; end
      else                  begin e_op1 = 0;        e_op2 = 0;        e_mode = 3;         end
      #1;
      tests++; if ({req0_ready, req1_ready} !== {(winner == 0) && can, (winner == 1) && can}) begin
        fails++; $display("FAIL rand_ready[%0d] got %b%b want %b%b", cyc, req0_ready, req1_ready,
                          (winner == 0) && can, (winner == 1) && can);
      end
      tests++; if ({alu_op1, alu_op2, alu_mode} !== {16'(e_op1), 16'(e_op2), 2'(e_mode)}) begin
        fails++; $display("FAIL rand_mux[%0d] got %h/%h/%b want %h/%h/%b", cyc, alu_op1, alu_op2, alu_mode,
                          16'(e_op1), 16'(e_op2), 2'(e_mode));
      end
      if (winner >= 0 && can) begin
        m_valid = 1'b1;
        m_data  = ref_alu(e_op1, e_op2, e_mode);
        m_id    = winner;
        m_last  = winner;
      end else if (m_valid && res_ready) begin
        m_valid = 1'b0;
      end
      @(posedge clk); #1;
      tests++; if ({res_valid, res_data, res_id} !== {m_valid, 16'(m_data), 1'(m_id)}) begin
        fails++; $display("FAIL rand_result[%0d] got v=%b d=%h id=%b want v=%b d=%h id=%b", cyc,
                          res_valid, res_data, res_id, m_valid, 16'(m_data), 1'(m_id));
      end
    end
    idle_drain();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    res_ready = 1'b1;
    set_req0(1'b0, '0, '0, 2'b00);
    set_req1(1'b0, '0, '0, 2'b00);
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_modes();
    test_idle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, datapath width of operands and result.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req0_valid  input  1  requester 0 presents an operation.
REQ-005 Port: req0_op1, req0_op2  input  WIDTH each  requester 0 operands.
REQ-006 Port: req0_mode  input  2  requester 0 ALU mode (00 add, 01 not Op1, 10 pass Op2, 11 nop/zero).
REQ-007 Port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 Port: req1_valid, req1_op1, req1_op2, req1_mode, req1_ready  same directions and widths as requester 0, for requester 1.
REQ-009 Port: alu_op1, alu_op2  output  WIDTH each  operands driven to the shared ALU.
REQ-010 Port: alu_mode  output  2  mode driven to the shared ALU.
REQ-011 Port: alu_result  input  WIDTH  combinational result from the shared ALU.
REQ-012 Port: res_valid  output  1  result register holds a result.
REQ-013 Port: res_data  output  WIDTH  registered ALU result.
REQ-014 Port: res_id  output  1  requester that owns res_data (0 or 1).
REQ-015 Port: res_ready  input  1  consumer takes the result this cycle.

Function
REQ-016 Transfer on a request port SHALL occur when reqN_valid and reqN_ready are both 1 on a rising edge; result transfer SHALL occur when res_valid and res_ready are both 1.
REQ-017 can_accept SHALL be 1 when res_valid is 0, or when res_valid and res_ready are both 1 (drain and refill in the same cycle).
REQ-018 Grant: only one valid -> that requester; both valid -> requester other than last_grant; none -> no grant.
REQ-019 reqN_ready SHALL equal (grant is N) AND can_accept; at most one ready high per cycle; ready SHALL NOT depend on reqN_ready of the other port.
REQ-020 When a requester is granted, alu_op1/alu_op2/alu_mode SHALL equal its operands and mode in the same cycle (combinational mux).
REQ-021 With no grant, alu_op1 and alu_op2 SHALL be 0 and alu_mode SHALL be 2'b11.
REQ-022 On an accepted request, the next edge SHALL load res_data <= alu_result, res_id <= granted index, res_valid <= 1; latency exactly 1 cycle.
REQ-023 res_valid 1 and res_ready 0 -> res_data, res_id, res_valid SHALL hold; both req ready outputs SHALL be 0.
REQ-024 Result drained with no accepted request -> res_valid SHALL go 0 next edge; res_data and res_id SHALL hold their last values.
REQ-025 last_grant SHALL update to the accepted index only on an accepted request; a grant that is not accepted (can_accept 0) SHALL not move it.
REQ-026 A requester whose valid is held SHALL be accepted within 2 accepted transfers (no starvation).
REQ-027 Mode 2'b11 requests SHALL be arbitrated and produce a result (value 0) like any other mode.
REQ-028 Arithmetic is the ALU's; the arbiter SHALL not modify alu_result (add wraps modulo 2^WIDTH upstream).

Reset
REQ-029 rst_n low SHALL immediately, without clk, force res_valid 0, res_data 0, res_id 0, last_grant 1 (requester 0 wins the first tie).
REQ-030 While rst_n low, req0_ready and req1_ready SHALL be 0.
REQ-031 rst_n asserted mid-operation SHALL discard any pending result; first edge after release SHALL behave as from idle.

Verification
REQ-032 Single: req0 valid, op1 0x0003, op2 0x0004, mode 00, res_ready 1 -> req0_ready 1 same cycle; next cycle res_valid 1, res_data 0x0007, res_id 0.
REQ-033 Tie after reset: both valid continuously, res_ready 1 -> accepted order 0,1,0,1; res_id sequence 0,1,0,1 on consecutive cycles.
REQ-034 Backpressure: result 0x00FF pending, res_ready 0 for 3 cycles with req1 valid -> res_data held 0x00FF, req1_ready 0 throughout; res_ready 1 -> req1 accepted same cycle.
REQ-035 Wrap/modes: op1 0xFFFF, op2 0x0001, mode 00 -> 0x0000; mode 01 op1 0x00F0 -> 0xFF0F; mode 10 op2 0x1234 -> 0x1234; mode 11 -> 0x0000.
REQ-036 Idle outputs: no valids -> alu_op1 0, alu_op2 0, alu_mode 11, both ready 0.
REQ-037 Reset mid-result: res_valid 1, pull rst_n low between edges -> res_valid 0 and res_data 0 immediately; after release, req1-only request is accepted and returns res_id 1.
